// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch unit: FSM encoding and default
// reset PC / bubble instruction.
package fetch_unit_pkg;

    localparam logic [1:0] S_REQ  = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_HOLD = 2'd2;
    localparam logic [1:0] S_DROP = 2'd3;

    localparam logic [31:0] DEF_RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] DEF_NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_unit.sv
// Single-outstanding-request instruction fetch stage: PCF register, request FSM,
// one-word hold buffer for ID stalls and the IF/ID pipeline register.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEF_RESET_PC,
    parameter logic [31:0] NOP_INSTR = DEF_NOP_INSTR
) (
    input  logic        CPU_CLK,
    input  logic        CPU_RST,
    input  logic [31:0] PC_In,
    input  logic        RedirectF,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    output logic        ImemReqValid,
    input  logic        ImemReqReady,
    output logic [31:0] ImemAddr,
    input  logic        ImemRspValid,
    input  logic [31:0] ImemRspData,
    output logic [31:0] PCF,
    output logic [31:0] PCD,
    output logic [31:0] InstrD,
    output logic        ValidD
);

    logic [1:0]  state, state_n;
    logic [31:0] pcf_n;
    logic [31:0] hbuf, hbuf_n;
    logic        load;
    logic [31:0] ldata;
    logic        accept;

    assign ImemReqValid = (state == S_REQ) && !StallF;
    assign ImemAddr     = PCF;
    assign accept       = ImemReqValid && ImemReqReady;

    always_comb begin
        state_n = state;
        pcf_n   = PCF;
        hbuf_n  = hbuf;
        load    = 1'b0;
        ldata   = ImemRspData;
        case (state)
            S_REQ: begin
                if (RedirectF)   pcf_n   = PC_In;
                else if (accept) state_n = S_WAIT;
            end
            S_WAIT: begin
                if (RedirectF) begin
                    pcf_n   = PC_In;
                    state_n = ImemRspValid ? S_REQ : S_DROP;
                end else if (ImemRspValid) begin
                    if (StallD) begin
                        hbuf_n  = ImemRspData;
                        state_n = S_HOLD;
                    end else begin
                        load    = 1'b1;
                        state_n = S_REQ;
                    end
                end
            end
            S_HOLD: begin
                if (RedirectF) begin
                    pcf_n   = PC_In;
                    hbuf_n  = '0;
                    state_n = S_REQ;
                end else if (!StallD) begin
                    load    = 1'b1;
                    ldata   = hbuf;
                    hbuf_n  = '0;
                    state_n = S_REQ;
                end
            end
            default: begin
                if (RedirectF)    pcf_n   = PC_In;
                if (ImemRspValid) state_n = S_REQ;
            end
        endcase
        // PC advances when a word is handed to ID, unless fetch is stalled
        if (load && !StallF) pcf_n = PC_In;
    end

    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            state <= S_REQ;
            PCF   <= RESET_PC;
            hbuf  <= '0;
        end else begin
            state <= state_n;
            PCF   <= pcf_n;
            hbuf  <= hbuf_n;
        end
    end

    // Flush beats stall beats load; anything else inserts a bubble
    always_ff @(posedge CPU_CLK or posedge CPU_RST) begin
        if (CPU_RST) begin
            PCD    <= '0;
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (FlushD) begin
            PCD    <= '0;
            InstrD <= NOP_INSTR;
            ValidD <= 1'b0;
        end else if (!StallD) begin
            if (load) begin
                PCD    <= PCF;
                InstrD <= ldata;
                ValidD <= 1'b1;
            end else begin
                PCD    <= '0;
                InstrD <= NOP_INSTR;
                ValidD <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit: directed vector table, reset corner sequence and a
// randomized run against a transaction-level reference model.
module tb_fetch_unit;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic N = 1'b0;
    localparam logic Y = 1'b1;

    logic        clk, rst;
    logic [31:0] pc_in;
    logic        redirect, stallf, stalld, flushd;
    logic        req_valid, req_ready;
    logic [31:0] addr;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [31:0] pcf, pcd, instr;
    logic        validd;

    int tests = 0;
    int fails = 0;

    fetch_unit dut (
        .CPU_CLK(clk), .CPU_RST(rst), .PC_In(pc_in), .RedirectF(redirect),
        .StallF(stallf), .StallD(stalld), .FlushD(flushd),
        .ImemReqValid(req_valid), .ImemReqReady(req_ready), .ImemAddr(addr),
        .ImemRspValid(rsp_valid), .ImemRspData(rsp_data),
        .PCF(pcf), .PCD(pcd), .InstrD(instr), .ValidD(validd)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rd, sf, sd, fd, rdy, rv;
        logic [31:0] rdat, pcin;
        logic        ereq;
        logic [31:0] epcf, epcd, einstr;
        logic        evld;
    } vec_t;

    vec_t tbl [0:16];

    // reference model state
    logic [31:0] m_pcf, m_pcd, m_instr, m_hbuf, n_pcf, ldat;
    logic        m_vld, m_pend, m_kill, m_hold, m_reqv, acc, ld;
    int          mem_cnt;
    logic [31:0] mem_addr;
    logic [31:0] prev_pcf;

    initial begin
        // one row per cycle: inputs, then request expected before the edge and ID/PC after it
        tbl[0]  = '{N,N,N,N,Y,N, 32'h0,        32'h4,        Y, 32'h0,        32'h0,        NOP,          N};
        tbl[1]  = '{N,N,N,N,N,Y, 32'h00100093, 32'h4,        N, 32'h4,        32'h0,        32'h00100093, Y};
        tbl[2]  = '{N,N,N,N,Y,N, 32'h0,        32'h8,        Y, 32'h4,        32'h0,        NOP,          N};
        tbl[3]  = '{Y,N,N,N,N,N, 32'h0,        32'h80,       N, 32'h80,       32'h0,        NOP,          N};
        tbl[4]  = '{N,N,N,N,N,Y, 32'h11111111, 32'h84,       N, 32'h80,       32'h0,        NOP,          N};
        tbl[5]  = '{N,N,N,N,Y,N, 32'h0,        32'h84,       Y, 32'h80,       32'h0,        NOP,          N};
        tbl[6]  = '{N,N,Y,N,N,Y, 32'hDEADBEEF, 32'h84,       N, 32'h80,       32'h0,        NOP,          N};
        tbl[7]  = '{N,N,Y,N,Y,N, 32'h0,        32'h84,       N, 32'h80,       32'h0,        NOP,          N};
        tbl[8]  = '{N,N,Y,N,Y,N, 32'h0,        32'h84,       N, 32'h80,       32'h0,        NOP,          N};
        tbl[9]  = '{N,N,N,N,N,N, 32'h0,        32'h84,       N, 32'h84,       32'h80,       32'hDEADBEEF, Y};
        tbl[10] = '{N,N,Y,N,Y,N, 32'h0,        32'h88,       Y, 32'h84,       32'h80,       32'hDEADBEEF, Y};
        tbl[11] = '{N,N,Y,Y,N,Y, 32'h22222222, 32'h88,       N, 32'h84,       32'h0,        NOP,          N};
        tbl[12] = '{N,N,N,N,N,N, 32'h0,        32'h88,       N, 32'h88,       32'h84,       32'h22222222, Y};
        tbl[13] = '{Y,N,N,N,N,N, 32'h0,        32'hFFFFFFFC, Y, 32'hFFFFFFFC, 32'h0,        NOP,          N};
        tbl[14] = '{N,N,N,N,Y,N, 32'h0,        32'h0,        Y, 32'hFFFFFFFC, 32'h0,        NOP,          N};
        tbl[15] = '{N,N,N,N,N,Y, 32'h33333333, 32'h0,        N, 32'h0,        32'hFFFFFFFC, 32'h33333333, Y};
        tbl[16] = '{N,Y,N,N,Y,N, 32'h0,        32'h4,        N, 32'h0,        32'h0,        NOP,          N};

        clk = 1'b0; rst = 1'b1;
        pc_in = '0; redirect = 0; stallf = 0; stalld = 0; flushd = 0;
        req_ready = 0; rsp_valid = 0; rsp_data = '0;
        repeat (2) @(negedge clk);
        chk("rst_pcf", pcf, 32'h0);
        chk("rst_pcd", pcd, 32'h0);
        chk("rst_instr", instr, NOP);
        chk("rst_valid", {31'b0, validd}, 32'h0);
        rst = 1'b0;

        prev_pcf = 32'h0;
        for (int i = 0; i <= 16; i++) begin
            redirect = tbl[i].rd; stallf = tbl[i].sf; stalld = tbl[i].sd; flushd = tbl[i].fd;
            req_ready = tbl[i].rdy; rsp_valid = tbl[i].rv; rsp_data = tbl[i].rdat; pc_in = tbl[i].pcin;
            #1;
            chk($sformatf("vec%0d_reqv", i), {31'b0, req_valid}, {31'b0, tbl[i].ereq});
            chk($sformatf("vec%0d_addr", i), addr, prev_pcf);
            step();
            chk($sformatf("vec%0d_pcf", i), pcf, tbl[i].epcf);
            chk($sformatf("vec%0d_pcd", i), pcd, tbl[i].epcd);
            chk($sformatf("vec%0d_instr", i), instr, tbl[i].einstr);
            chk($sformatf("vec%0d_valid", i), {31'b0, validd}, {31'b0, tbl[i].evld});
            prev_pcf = tbl[i].epcf;
        end
        redirect = 0; stallf = 0; stalld = 0; flushd = 0; req_ready = 0; rsp_valid = 0;

        // reset while a request to 0x40 is outstanding
        redirect = 1; pc_in = 32'h40;
        step();
        redirect = 0; req_ready = 1;
        #1;
        chk("rstseq_addr40", addr, 32'h40);
        step();
        req_ready = 0;
        #2 rst = 1'b1;
        #1;
        chk("rstseq_async_pcf", pcf, 32'h0);
        chk("rstseq_async_valid", {31'b0, validd}, 32'h0);
        @(negedge clk);
        rst = 1'b0; rsp_valid = 1; rsp_data = 32'hBAD0BAD0;
        #1;
        chk("rstseq_reqv", {31'b0, req_valid}, 32'h1);
        step();
        chk("rstseq_stale_valid", {31'b0, validd}, 32'h0);
        chk("rstseq_stale_instr", instr, NOP);
        chk("rstseq_pcf", pcf, 32'h0);
        rsp_valid = 0; req_ready = 1; pc_in = 32'h4;
        #1;
        chk("rstseq_first_addr", addr, 32'h0);
        step();
        req_ready = 0; rsp_valid = 1; rsp_data = 32'h00100093;
        step();
        rsp_valid = 0;
        chk("rstseq_load_valid", {31'b0, validd}, 32'h1);
        chk("rstseq_load_pcd", pcd, 32'h0);
        chk("rstseq_load_instr", instr, 32'h00100093);
        chk("rstseq_load_pcf", pcf, 32'h4);

        // randomized run against the reference model
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_pcf = 32'h0; m_pcd = 32'h0; m_instr = NOP; m_vld = 0;
        m_pend = 0; m_kill = 0; m_hold = 0; m_hbuf = '0;
        mem_cnt = 0; mem_addr = '0;
        for (int c = 0; c < 3000; c++) begin
            redirect  = ($urandom_range(0, 9) == 0);
            stallf    = ($urandom_range(0, 6) == 0);
            stalld    = ($urandom_range(0, 3) == 0);
            flushd    = ($urandom_range(0, 9) == 0);
            req_ready = ($urandom_range(0, 9) < 7);
            pc_in     = $urandom_range(0, 1) ? m_pcf + 32'd4 : $urandom;
            rsp_valid = (mem_cnt == 1);
            rsp_data  = mem_addr ^ 32'hC0DE_0000;
            #1;
            m_reqv = !m_pend && !m_kill && !m_hold && !stallf;
            chk("rnd_reqv", {31'b0, req_valid}, {31'b0, m_reqv});
            chk("rnd_addr", addr, m_pcf);
            acc = m_reqv && req_ready;

            n_pcf = m_pcf; ld = 0; ldat = '0;
            if (redirect) begin
                n_pcf = pc_in;
                m_hold = 0;
                if (m_pend) begin
                    m_pend = 0;
                    m_kill = !rsp_valid;
                end else if (m_kill && rsp_valid) m_kill = 0;
            end else if (acc) begin
                m_pend = 1;
            end else if (m_pend && rsp_valid) begin
                m_pend = 0;
                if (stalld) begin m_hold = 1; m_hbuf = rsp_data; end
                else begin ld = 1; ldat = rsp_data; end
            end else if (m_hold && !stalld) begin
                m_hold = 0; ld = 1; ldat = m_hbuf;
            end else if (m_kill && rsp_valid) begin
                m_kill = 0;
            end
            if (ld && !stallf) n_pcf = pc_in;
            if (flushd) begin
                m_pcd = 0; m_instr = NOP; m_vld = 0;
            end else if (!stalld) begin
                if (ld) begin m_pcd = m_pcf; m_instr = ldat; m_vld = 1; end
                else begin m_pcd = 0; m_instr = NOP; m_vld = 0; end
            end

            if (mem_cnt > 0) mem_cnt--;
            if (acc) begin
                mem_cnt  = $urandom_range(1, 3);
                mem_addr = m_pcf;
            end
            m_pcf = n_pcf;

            step();
            chk("rnd_pcf", pcf, m_pcf);
            chk("rnd_pcd", pcd, m_pcd);
            chk("rnd_instr", instr, m_instr);
            chk("rnd_valid", {31'b0, validd}, {31'b0, m_vld});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
